rvfi_dmem_responder: RTL and testbench

RVFI_DMEM_RESPONDER -- requirements
Module: rvfi_dmem_responder

---
 rtl/rvfi_dmem_pkg.sv | 21 ++
 rtl/rvfi_dmem_ram.sv | 35 +++
 rtl/rvfi_dmem_responder.sv | 139 +++++++++++++
 tb/tb_rvfi_dmem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_dmem_pkg.sv
// Shared types and address-decode helpers for the RVFI data-memory responder.
package rvfi_dmem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned CntW = 4;

  // Byte-offset bits inside one XLEN-wide word.
  function automatic int unsigned off_bits(input int unsigned xlen);
    return $clog2(xlen / 8);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rvfi_dmem_ram.sv
// DEPTH x XLEN word storage: asynchronous read of the current contents, byte-masked
// synchronous write and synchronous clear, so a same-edge capture sees the pre-write word.
module rvfi_dmem_ram
  import rvfi_dmem_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 16,
  localparam int unsigned IdxW     = idx_bits(DEPTH),
  localparam int unsigned NumBytes = XLEN / 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [IdxW-1:0]     i_idx,
  input  logic [NumBytes-1:0] i_wstrb,
  input  logic [XLEN-1:0]     i_wdata,
  output logic [XLEN-1:0]     o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_idx];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem <= '{default: '0};
    end else begin
      for (int b = 0; b < NumBytes; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/rvfi_dmem_responder.sv
// Single-outstanding data-memory responder: accept, wait LATENCY cycles, then respond with
// the pre-write word while applying the masked write on the same edge.
module rvfi_dmem_responder
  import rvfi_dmem_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LATENCY  = 2,
  localparam int unsigned NumBytes = XLEN / 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [NumBytes-1:0] req_wstrb,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned OffW = off_bits(XLEN);
  localparam int unsigned IdxW = idx_bits(DEPTH);
  localparam int unsigned TopLo = OffW + IdxW;

  state_e              r_state, w_state_nxt;
  logic [CntW-1:0]     r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]     r_addr, w_addr_nxt;
  logic [XLEN-1:0]     r_wdata, w_wdata_nxt;
  logic [NumBytes-1:0] r_wstrb, w_wstrb_nxt;
  logic [XLEN-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;

  logic                w_accept;
  logic                w_enter_resp;
  logic                w_acc_err;
  logic [XLEN-1:0]     w_acc_addr;
  logic [XLEN-1:0]     w_acc_wdata;
  logic [NumBytes-1:0] w_acc_wstrb;
  logic [NumBytes-1:0] w_ram_wstrb;
  logic [XLEN-1:0]     w_ram_rdata;
  logic [IdxW-1:0]     w_idx;

  assign req_ready = resetn && (r_state == StIdle);
  assign w_accept  = req_valid && req_ready;

  // With LATENCY=0 storage is accessed on the accept edge, so use the live request there.
  assign w_acc_addr  = (r_state == StIdle) ? req_addr  : r_addr;
  assign w_acc_wstrb = (r_state == StIdle) ? req_wstrb : r_wstrb;
  assign w_acc_wdata = (r_state == StIdle) ? req_wdata : r_wdata;

  assign w_idx       = w_acc_addr[OffW +: IdxW];
  assign w_acc_err   = (w_acc_addr[OffW-1:0] != '0) || (w_acc_addr[XLEN-1:TopLo] != '0);
  assign w_ram_wstrb = (w_enter_resp && !w_acc_err) ? w_acc_wstrb : '0;

  rvfi_dmem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .i_idx   (w_idx),
    .i_wstrb (w_ram_wstrb),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_wstrb_nxt     = r_wstrb;
    w_wdata_nxt     = r_wdata;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_enter_resp    = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_addr_nxt  = req_addr;
          w_wstrb_nxt = req_wstrb;
          w_wdata_nxt = req_wdata;
          if (LATENCY == 0) begin
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = StWait;
            w_cnt_nxt   = CntW'(LATENCY);
          end
        end
      end
      StWait: begin
        w_cnt_nxt = r_cnt - CntW'(1);
        if (r_cnt <= CntW'(1)) begin
          w_enter_resp = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_enter_resp) begin
      w_state_nxt     = StResp;
      w_rsp_rdata_nxt = w_acc_err ? '0 : w_ram_rdata;
      w_rsp_err_nxt   = w_acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wstrb     <= '0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign rsp_valid = (r_state == StResp);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_rvfi_dmem_responder.sv
// Directed bench: a LATENCY=2 responder for the main scenarios and a LATENCY=0 one for
// back-to-back throughput.
module tb_rvfi_dmem_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wstrb;

  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rvfi_dmem_responder #(
    .XLEN    (32),
    .DEPTH   (16),
    .LATENCY (2)
  ) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wstrb (req_wstrb),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  rvfi_dmem_responder #(
    .XLEN    (32),
    .DEPTH   (16),
    .LATENCY (0)
  ) u_dut_l0 (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_addr  (b_req_addr),
    .req_wstrb (b_req_wstrb),
    .req_wdata (b_req_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; hold>0 keeps rsp_ready low that many cycles.
  task automatic a_txn(input string tag, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                       input int hold);
    int k;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_wstrb = s;
    req_wdata = d;
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = '0;
    req_wstrb = '0;
    req_wdata = '0;
    k = 1;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, 32'(k), 32'd3);
    chk({tag, ".rdata"}, rsp_rdata, exp_d);
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h0;
      req_wstrb = 4'hF;
      req_wdata = 32'h1234_5678;
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata, exp_d);
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    req_wstrb = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".done"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic b_txn(input string tag, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp_d);
    int k;
    chk({tag, ".req_ready"}, 32'(b_req_ready), 32'd1);
    b_req_valid = 1'b1;
    b_req_addr  = a;
    b_req_wstrb = s;
    b_req_wdata = d;
    @(negedge clk);
    b_req_valid = 1'b0;
    b_req_wstrb = '0;
    k = 1;
    while (!b_rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, 32'(k), 32'd1);
    chk({tag, ".rdata"}, b_rsp_rdata, exp_d);
    @(negedge clk);
    chk({tag, ".done"}, 32'(b_rsp_valid), 32'd0);
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_wstrb = '0; req_wdata = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_addr = '0; b_req_wstrb = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b1;

    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.b_req_ready", 32'(b_req_ready), 32'd0);
    resetn = 1'b1;
    #1;
    chk("rst.ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);

    a_txn("wr8",   32'h8,  4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0, 0);
    a_txn("rd8",   32'h8,  4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
    a_txn("pw8",   32'h8,  4'h2, 32'h0000_AA00, 32'hDEAD_BEEF, 1'b0, 0);
    a_txn("rd8b",  32'h8,  4'h0, 32'h0,         32'hDEAD_AAEF, 1'b0, 0);
    a_txn("rd6",   32'h6,  4'h0, 32'h0,         32'h0,         1'b1, 0);
    a_txn("rd40",  32'h40, 4'h0, 32'h0,         32'h0,         1'b1, 0);
    a_txn("wrA",   32'hA,  4'hF, 32'h1111_1111, 32'h0,         1'b1, 0);
    a_txn("wr40",  32'h40, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 0);
    a_txn("rd8c",  32'h8,  4'h0, 32'h0,         32'hDEAD_AAEF, 1'b0, 0);
    a_txn("rd0",   32'h0,  4'h0, 32'h0,         32'h0,         1'b0, 0);
    a_txn("stall", 32'h8,  4'h0, 32'h0,         32'hDEAD_AAEF, 1'b0, 5);
    a_txn("rd0b",  32'h0,  4'h0, 32'h0,         32'h0,         1'b0, 0);
    a_txn("wr3c",  32'h3C, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0, 0);
    a_txn("rd3c",  32'h3C, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0, 0);

    // Reset while the write to 0x4 is sitting in WAIT.
    req_valid = 1'b1; req_addr = 32'h4; req_wstrb = 4'hF; req_wdata = 32'h5555_5555;
    @(negedge clk);
    req_valid = 1'b0; req_wstrb = '0;
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst.req_ready", 32'(req_ready), 32'd0);
    resetn = 1'b1;
    #1;
    chk("midrst.ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst.no_rsp", 32'(rsp_valid), 32'd0);
    end
    a_txn("rd4",    32'h4, 4'h0, 32'h0, 32'h0, 1'b0, 0);
    a_txn("rd8rst", 32'h8, 4'h0, 32'h0, 32'h0, 1'b0, 0);

    // LATENCY=0 back-to-back: accepts every other cycle, alternating addresses.
    b_txn("b.wr0", 32'h0, 4'hF, 32'hA5A5_A5A5, 32'h0);
    b_txn("b.wr4", 32'h4, 4'hF, 32'h5A5A_5A5A, 32'h0);
    b_req_valid = 1'b1;
    b_req_addr  = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("b2b.rsp_valid", 32'(b_rsp_valid), 32'(i % 2));
      chk("b2b.req_ready", 32'(b_req_ready), 32'((i + 1) % 2));
      if (i % 2 == 1) begin
        chk("b2b.rdata", b_rsp_rdata, (((i - 1) / 2) % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A);
        b_req_addr = (((i + 1) / 2) % 2 == 0) ? 32'h0 : 32'h4;
      end
    end
    b_req_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
